// File: rtl/dlx_fetch_stage.sv
// ============================================================================
// Module   : dlx_fetch_stage
// Purpose  : DLX instruction fetch with req/rdy memory handshake and IF/ID
//            register. Optional perf counters: define DLX_FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlx_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  funct,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        // Without stall, IF/ID becomes a bubble unless a word lands this cycle
        if (!stall) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_rdy) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // pc already advanced past the buffered word, so it is its pc+4
                if (!stall) begin
                    ifid_instr_d = buf_q;
                    ifid_pc4_d   = pc_q;
                    ifid_valid_d = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rdy) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            pc_d         = redirect_pc;
            buf_d        = NOP_INSTR;
            if (state_q == ST_REQ) begin
                state_d = imem_rdy ? ST_REQ : ST_DROP;
            end else if (state_q == ST_HOLD) begin
                state_d = ST_REQ;
            end
        end
    end

    // An abandoned request keeps its address on the bus until it completes
    assign addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
    assign req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            buf_q        <= NOP_INSTR;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            buf_q        <= buf_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign Opcode     = ifid_instr_q[31:26];
    assign funct      = ifid_instr_q[5:0];

`ifdef DLX_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A valid word with stall low can only be a fresh IF/ID load
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ifid_valid_d && !stall) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (stall)                  stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dlx_fetch_stage.sv
// ============================================================================
// Module   : tb_dlx_fetch_stage
// Purpose  : Randomized and directed bench for dlx_fetch_stage against a
//            word-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dlx_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  Opcode;
    logic [5:0]  funct;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    dlx_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .Opcode(Opcode), .funct(funct),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a fetch address, an optional "discard next response"
    // marker, a queue of stalled words and the IF/ID contents.
    bit          m_boot, m_discard, m_valid;
    logic [31:0] m_pc, m_addr, m_instr, m_pc4, m_fetch, m_stalls;
    logic [63:0] m_held[$];
    bit          rand_data = 1'b0;

    function automatic void model_reset();
        m_boot = 1; m_discard = 0; m_valid = 0;
        m_pc = RESET_PC; m_addr = RESET_PC;
        m_instr = NOP_INSTR; m_pc4 = 32'd0;
        m_fetch = 0; m_stalls = 0;
        m_held.delete();
    endfunction

    function automatic bit model_req();
        return !m_boot && (m_held.size() == 0);
    endfunction

    function automatic void model_edge();
        bit          req_now = model_req();
        bit          loaded = 0;
        logic [63:0] w;
        if (stall) m_stalls++;
        if (redirect) begin
            m_instr = NOP_INSTR; m_valid = 0;
            m_held.delete();
            if (req_now && !imem_rdy) m_discard = 1;
            else if (req_now)         m_discard = 0;
            m_pc = redirect_pc;
            m_boot = 0;
        end else if (m_boot) begin
            m_boot = 0;
            if (!stall) begin m_instr = NOP_INSTR; m_valid = 0; end
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                w = m_held.pop_front();
                m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1; loaded = 1;
            end
        end else if (imem_rdy) begin
            if (m_discard) begin
                m_discard = 0;
                if (!stall) begin m_instr = NOP_INSTR; m_valid = 0; end
            end else begin
                w = {imem_rdata, m_pc + 32'd4};
                m_pc = m_pc + 32'd4;
                if (stall) m_held.push_back(w);
                else begin m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1; loaded = 1; end
            end
        end else if (!stall) begin
            m_instr = NOP_INSTR; m_valid = 0;
        end
        if (!m_discard) m_addr = m_pc;
        if (loaded) m_fetch++;
    endfunction

    task automatic compare_all();
        check_val("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
        if (model_req()) check_val("imem_addr", imem_addr, m_addr);
        check_val("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        check_val("ifid_instr", ifid_instr, m_instr);
        check_val("Opcode", {26'd0, Opcode}, {26'd0, m_instr[31:26]});
        check_val("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
        if (m_valid) check_val("ifid_pc4", ifid_pc4, m_pc4);
`ifdef DLX_FETCH_PERF_EN
        check_val("fetch_cnt", fetch_cnt, m_fetch);
        check_val("stall_cnt", stall_cnt, m_stalls);
`else
        check_val("fetch_cnt", fetch_cnt, 32'd0);
        check_val("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    // Drive inputs for the next edge, clock it, then compare 1 ns later
    task automatic step(input bit st, input bit rd, input bit rdr, input logic [31:0] rpc);
        stall = st; imem_rdy = rd; redirect = rdr; redirect_pc = rpc;
        imem_rdata = rand_data ? $urandom : (imem_addr | 32'h2000_0000);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 0; imem_rdy = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Zero-wait streaming
        repeat (6) step(0, 1, 0, 0);
        // Two-cycle stall: one word buffered, request dropped
        repeat (2) step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        // Redirect while streaming
        step(0, 1, 1, 32'h0000_0100);
        repeat (3) step(0, 1, 0, 0);
        // Wait-state memory, redirect during wait cycle 2
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0200);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_val("pc4_after_drop", ifid_pc4, 32'h0000_0204);
        step(0, 1, 0, 0);
        // Redirect + stall with a full HOLD buffer
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h0000_0300);
        repeat (3) step(0, 1, 0, 0);
        // Address wrap
        step(0, 1, 1, 32'hFFFF_FFF8);
        repeat (4) step(0, 1, 0, 0);
        // Reset asserted mid-DROP
        step(0, 0, 1, 32'h0000_0400);
        #2;
        do_reset();
        step(0, 1, 0, 0);
        check_val("first_fetch_addr", imem_addr, RESET_PC);
        step(0, 1, 0, 0);

        // Counter scenario: 10 streamed words then 3 stall cycles
        do_reset();
        repeat (11) step(0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
`ifdef DLX_FETCH_PERF_EN
        check_val("fetch_cnt_10", fetch_cnt, 32'd10);
        check_val("stall_cnt_3", stall_cnt, 32'd3);
`else
        check_val("fetch_cnt_off", fetch_cnt, 32'd0);
        check_val("stall_cnt_off", stall_cnt, 32'd0);
`endif

        // Randomized traffic
        do_reset();
        rand_data = 1'b1;
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
                 (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
